// File: rtl/aps_adder_pkg.sv
// Shared types and sizing helpers for the chunked adder/subtractor.
package aps_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    // Number of slices needed to cover the full operand.
    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    localparam int NCHUNK = nchunk(DEF_WIDTH, DEF_CHUNK);

    // Slice index width; a single-slice configuration still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Narrow combinational adder slice reused for every chunk of the operands.
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // Plain ripple sum with the carry appended as the top bit.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_adder32.sv
// Multi-cycle adder/subtractor: one CHUNK-wide slice per clock, valid/ready on both sides.
module chunked_adder32
    import aps_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Pin,
    input  logic             SUB,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] S,
    output logic             Pout,
    output logic             OVF
);

    localparam int NCH   = nchunk(WIDTH, CHUNK);
    localparam int IDX_W = idx_width(NCH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("chunked_adder32: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   bx_q, bx_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic               pout_q, pout_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   sl_a, sl_b, sl_s;
    logic               sl_c;

    // The slice always looks at the chunk selected by the running index.
    assign sl_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign sl_b = bx_q[int'(idx_q) * CHUNK +: CHUNK];

    adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_c)
    );

    // Next-state, operand capture, per-chunk accumulation and flag generation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        bx_d    = bx_q;
        s_d     = s_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        pout_d  = pout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    // Subtraction is A + ~B + ~borrow, so invert B and the carry-in here once.
                    a_d     = A;
                    bx_d    = B ^ {WIDTH{SUB}};
                    carry_d = Pin ^ SUB;
                    sub_d   = SUB;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                s_d[int'(idx_q) * CHUNK +: CHUNK] = sl_s;
                carry_d = sl_c;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    // Carry-out is inverted back into a borrow for subtraction.
                    pout_d  = sl_c ^ sub_q;
                    ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) && (sl_s[CHUNK-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            bx_q    <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            pout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            pout_q  <= pout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_out = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign S         = s_q;
    assign Pout      = pout_q;
    assign OVF       = ovf_q;

endmodule

// File: tb/tb_chunked_adder32.sv
// Scoreboard bench: three adder instances (CHUNK 8, 32, 4) against an arithmetic reference.
module tb_chunked_adder32;

    typedef struct packed {
        logic [31:0] s;
        logic        pout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        vin    [3];
    logic        rdyo   [3];
    logic [31:0] a_in   [3];
    logic [31:0] b_in   [3];
    logic        pin_in [3];
    logic        sub_in [3];
    logic        vout   [3];
    logic        rin    [3];
    logic [31:0] s_out  [3];
    logic        pout   [3];
    logic        ovf    [3];

    exp_t exp_q [3][$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            localparam int CH = (gi == 0) ? 8 : ((gi == 1) ? 32 : 4);
            chunked_adder32 #(.WIDTH(32), .CHUNK(CH)) u_dut (
                .clk       (clk),
                .rst       (rst),
                .valid_in  (vin[gi]),
                .ready_out (rdyo[gi]),
                .A         (a_in[gi]),
                .B         (b_in[gi]),
                .Pin       (pin_in[gi]),
                .SUB       (sub_in[gi]),
                .valid_out (vout[gi]),
                .ready_in  (rin[gi]),
                .S         (s_out[gi]),
                .Pout      (pout[gi]),
                .OVF       (ovf[gi])
            );
        end
    endgenerate

    // Reference: exact integer arithmetic, then reduce to the reported fields.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic pin, input logic sub);
        exp_t   e;
        longint ua, ub, sa, sb, pl, us, ss;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        pl = pin ? 64'sd1 : 64'sd0;
        if (!sub) begin
            us     = ua + ub + pl;
            ss     = sa + sb + pl;
            e.pout = (us > 64'sd4294967295);
        end else begin
            us     = ua - ub - pl;
            ss     = sa - sb - pl;
            e.pout = (us < 0);
        end
        e.s   = us[31:0];
        e.ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per completed output handshake.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int k = 0; k < 3; k++) begin
                    if (vout[k]) begin
                        chk($sformatf("ready_out_in_done_inst%0d", k), 64'(rdyo[k]), 64'd0);
                    end
                    if (vout[k] && rin[k]) begin
                        if (exp_q[k].size() == 0) begin
                            chk($sformatf("unexpected_result_inst%0d", k), 64'd1, 64'd0);
                        end else begin
                            e = exp_q[k].pop_front();
                            chk($sformatf("result_inst%0d", k),
                                64'({s_out[k], pout[k], ovf[k]}), 64'(e));
                            $display("txn inst=%0d S=%h Pout=%b OVF=%b exp S=%h Pout=%b OVF=%b",
                                     k, s_out[k], pout[k], ovf[k], e.s, e.pout, e.ovf);
                        end
                    end
                end
            end
        end
    endtask

    // Issue one operation; returns one delta after the accepting edge.
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic p, input logic sb, input exp_t e, input bit push);
        int n;
        n = 0;
        while (!rdyo[k] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdyo[k]) begin
            chk($sformatf("accept_timeout_inst%0d", k), 64'(rdyo[k]), 64'd1);
            return;
        end
        a_in[k]   = a;
        b_in[k]   = b;
        pin_in[k] = p;
        sub_in[k] = sb;
        vin[k]    = 1'b1;
        if (push) exp_q[k].push_back(e);
        @(posedge clk);
        #1;
        vin[k]    = 1'b0;
        // Scramble the operand bus; the block must have sampled only at acceptance.
        a_in[k]   = $urandom;
        b_in[k]   = $urandom;
        pin_in[k] = 1'($urandom);
        sub_in[k] = 1'($urandom);
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || !rdyo[k]) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("drain_timeout_inst%0d", k), 64'(exp_q[k].size()), 64'd0);
    endtask

    task automatic run_rand(input int k, input int count);
        logic [31:0] a, b;
        logic        p, sb;
        for (int i = 0; i < count; i++) begin
            a  = pick_operand();
            b  = pick_operand();
            p  = 1'($urandom);
            sb = 1'($urandom);
            do_op(k, a, b, p, sb, model(a, b, p, sb), 1'b1);
        end
        wait_drain(k);
    endtask

    initial begin
        int   cnt;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            vin[k] = 1'b0; a_in[k] = '0; b_in[k] = '0;
            pin_in[k] = 1'b0; sub_in[k] = 1'b0; rin[k] = 1'b1;
        end
        fork
            monitor_loop();
        join_none

        // Reset state of every instance
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready_out_inst%0d", k), 64'(rdyo[k]), 64'd1);
            chk($sformatf("rst_valid_out_inst%0d", k), 64'(vout[k]), 64'd0);
            chk($sformatf("rst_S_inst%0d", k), 64'(s_out[k]), 64'd0);
            chk($sformatf("rst_Pout_inst%0d", k), 64'(pout[k]), 64'd0);
            chk($sformatf("rst_OVF_inst%0d", k), 64'(ovf[k]), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add with latency measurement
        e = '{s: 32'd400, pout: 1'b0, ovf: 1'b0};
        do_op(0, 32'd100, 32'd300, 1'b0, 1'b0, e, 1'b1);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!vout[0] && cnt < 50);
        chk("latency_edges", 64'(cnt), 64'd4);
        wait_drain(0);

        // Carry-in, unsigned wrap, signed overflow, subtract with borrow
        e = '{s: 32'd1717, pout: 1'b0, ovf: 1'b0};
        do_op(0, 32'd228, 32'd1488, 1'b1, 1'b0, e, 1'b1);
        e = '{s: 32'h0000_0000, pout: 1'b1, ovf: 1'b0};
        do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, e, 1'b1);
        e = '{s: 32'h8000_0000, pout: 1'b0, ovf: 1'b1};
        do_op(0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, e, 1'b1);
        e = '{s: 32'hFFFF_FFFE, pout: 1'b1, ovf: 1'b0};
        do_op(0, 32'd5, 32'd7, 1'b0, 1'b1, e, 1'b1);
        wait_drain(0);

        // Back-pressure: result must hold for 10 cycles in DONE
        rin[0] = 1'b0;
        e = '{s: 32'h7FFF_FFFF, pout: 1'b0, ovf: 1'b1};
        do_op(0, 32'h8000_0000, 32'd1, 1'b0, 1'b1, e, 1'b1);
        cnt = 0;
        while (!vout[0] && cnt < 50) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("bp_valid_rise", 64'(vout[0]), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid_held", 64'(vout[0]), 64'd1);
            chk("bp_ready_out", 64'(rdyo[0]), 64'd0);
            chk("bp_S", 64'(s_out[0]), 64'(e.s));
            chk("bp_flags", 64'({pout[0], ovf[0]}), 64'({e.pout, e.ovf}));
        end
        rin[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 64'(vout[0]), 64'd0);
        chk("bp_release_ready", 64'(rdyo[0]), 64'd1);
        wait_drain(0);

        // Reset mid-CALC aborts the operation
        do_op(0, 32'd10, 32'd20, 1'b0, 1'b0, e, 1'b0);
        @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        chk("abort_valid_out", 64'(vout[0]), 64'd0);
        chk("abort_ready_out", 64'(rdyo[0]), 64'd1);
        chk("abort_S", 64'(s_out[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", 64'(vout[0]), 64'd0);
        end
        e = '{s: 32'd2, pout: 1'b0, ovf: 1'b0};
        do_op(0, 32'd1, 32'd1, 1'b0, 1'b0, e, 1'b1);
        wait_drain(0);

        // Randomized regression on all three chunk configurations in parallel
        fork
            run_rand(0, 300);
            run_rand(1, 1000);
            run_rand(2, 1000);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
